jk_counter_sequencer: RTL and testbench
=======================================

Name: jk_counter_sequencer

Overview:
- Controller that sequences a bank of WIDTH JK flip-flop cells as a programmable modulo-M up/down counter.
- Per cycle it computes each cell's J/K drive from current Q and the requested next state; it never drives the cells' async set/clear pins.
- Provides a start/done run handshake, level pause, stop, and parallel load.
- Sits above the lab's JK flip-flop cells, as the sequencing layer used by counter and display experiments.

Parameters:
- WIDTH, 4, number of JK cells (counter bits).
- DEF_MOD, 10, modulus used when the latched modulus is 0 and WIDTH=4 builds are run without configuration; otherwise 0 means 2^WIDTH.

Ports:
- clk  in  1  rising-edge clock, the only clock
- rd  in  1  synchronous, active-high reset
- start  in  1  begin a run (sampled in IDLE)
- stop  in  1  abort run (RUN/PAUSE → IDLE)
- pause  in  1  level; hold counter while high during a run
- dir  in  1  1=up, 0=down; latched at start
- modulus  in  WIDTH  M; 0 means 2^WIDTH; 1 is illegal; latched at start
- run_len  in  WIDTH  steps to execute; 0 = free-run until stop; latched at start
- load  in  1  parallel-load request (honoured in IDLE/PAUSE only)
- load_val  in  WIDTH  load value
- q  out  WIDTH  cell-bank state
- j  out  WIDTH  J drive to cells (observation)
- k  out  WIDTH  K drive to cells (observation)
- carry  out  1  one-cycle pulse on wrap
- busy  out  1  high in RUN or PAUSE
- done  out  1  one-cycle pulse on run completion
- err  out  1  one-cycle pulse on illegal request

Behaviour:
- Reset (rd=1 at an edge):
  - q=0, state IDLE.
  - carry, done and err are 0; busy=0.
  - Latched modulus, dir and run_len are cleared.
  - Reset mid-run aborts without a done pulse.
- States:
  - IDLE: j=k=0.
    - start with modulus≠1 → RUN; latch modulus, dir and run_len, set remaining=run_len.
    - start with modulus=1 → err pulse; stay IDLE.
  - RUN: one step per cycle.
    - Up: next=(q+1) mod M. Down: next=(q==0 ? M-1 : q-1).
    - carry=1 in the cycle the wrap edge is taken: up with q=M-1, or down with q=0.
    - If run_len≠0: remaining decrements per step; the step where remaining==1 moves to DONE.
  - PAUSE: entered from RUN when pause=1; j=k=0; returns to RUN when pause=0.
  - DONE: single cycle, done=1, j=k=0 → IDLE.
- Cell drive:
  - j[i]=k[i]=q[i]^next[i], so only changing bits toggle.
  - Hold means j=k=0.
  - Load means next=load_val, using the same toggle encoding.
- Timing: j/k are combinational from q and state; q updates on the following edge.
  - start high in cycle 0 → busy at edge 1 → first count edge 2.
- Outputs: busy, done, carry and err are registered flags aligned with the state and q they describe.
- Load:
  - In IDLE/PAUSE, load_val<M_eff → q=load_val next edge.
  - load_val≥M_eff → q unchanged, err pulse.
  - In IDLE, M_eff is the modulus input, not the latched value.
  - load in RUN is ignored, with no err.
- Priorities: rd > stop > load > pause > start/step.
  - start and load together in IDLE: load only; start ignored.
  - stop and pause together: stop wins.
  - stop in RUN/PAUSE → IDLE next edge, q held, no done.
- Out-of-range q at start (q≥M after a modulus change): first step forces next=0 with no carry.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - an M_eff helper (0→2^WIDTH);
  - the JK toggle-encoding function.
- Sub-module jk_cell_bank: WIDTH synchronous JK cells.
  - Inputs: clk, rd (clear), j, k.
  - Output: q.
  - Behaviour: Q+ = J&~Q | ~K&Q.
- The sequencer contains only the FSM, remaining counter, next-state arithmetic and flags.

Test Plan:
- Reset then idle: rd=1 for 2 cycles, then start=0 → q=0, busy=0, j=k=0, all pulses low.
- Up count mod 10 free-run: modulus=10, dir=1, run_len=0, start → q walks 0..9,0; carry high exactly at the 9→0 edge; j=k=4'b1001 at q=9.
- Down count with length: modulus=6, dir=0, run_len=4, load_val=2 preloaded → q 2,1,0,5,4; carry on the 0→5 edge; done one cycle after the final step; then busy=0.
- Pause/stop interplay: pause high for 3 cycles mid-run → q frozen, j=k=0; then stop and pause together → IDLE, no done pulse.
- Illegal requests:
  - modulus=1 with start → err pulse, stays IDLE.
  - load_val=12 with modulus=10 in IDLE → err, q unchanged.
  - load during RUN → ignored.
- Full range: modulus=0, WIDTH=4, up → q wraps 15→0 with carry; rd asserted mid-run → q=0, no done.

Source files
------------

// File: rtl/jk_counter_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// jk_counter_sequencer_pkg
// Shared definitions for the JK counter sequencer:
//   state_t   - sequencer FSM states
//   m_eff     - effective modulus (a programmed 0 means the full 2^width range)
//   jk_toggle - J/K drive for one cell that moves q to nxt (toggle encoding)
// ---------------------------------------------------------------------------
package jk_counter_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A modulus of 0 selects the full binary range of the counter.
  function automatic int m_eff(input int m, input int width);
    return (m == 0) ? (1 << width) : m;
  endfunction

  // Drive J=K=1 only on bits that must change; J=K=0 holds the cell.
  function automatic logic jk_toggle(input logic q_bit, input logic nxt_bit);
    return q_bit ^ nxt_bit;
  endfunction

endpackage

// File: rtl/jk_counter_sequencer_jk_cell_bank.sv
// ---------------------------------------------------------------------------
// jk_cell_bank
// WIDTH synchronous JK flip-flop cells sharing one clock and a synchronous
// clear. Each cell follows Q+ = J&~Q | ~K&Q.
// Ports:
//   clk - rising-edge clock
//   rd  - synchronous active-high clear of every cell
//   j   - per-cell J input
//   k   - per-cell K input
//   q   - per-cell state
// ---------------------------------------------------------------------------
module jk_cell_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rd,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      always_ff @(posedge clk) begin
        if (rd) begin
          q[gi] <= 1'b0;
        end else begin
          q[gi] <= (j[gi] & ~q[gi]) | (~k[gi] & q[gi]);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/jk_counter_sequencer.sv
// ---------------------------------------------------------------------------
// jk_counter_sequencer
// Sequences a bank of WIDTH JK cells as a programmable modulo-M up/down
// counter with a start/done run handshake, level pause, stop and parallel
// load. The cells hold the count; this block only computes their J/K drive.
// Ports:
//   clk      - rising-edge clock
//   rd       - synchronous active-high reset
//   start    - begin a run (IDLE only)
//   stop     - abort a run back to IDLE, count held, no done
//   pause    - level; freezes the count while high during a run
//   dir      - 1=up, 0=down (latched at start)
//   modulus  - M, 0 means 2^WIDTH, 1 is rejected (latched at start)
//   run_len  - steps per run, 0 = free-run (latched at start)
//   load     - parallel load request (IDLE/PAUSE)
//   load_val - value to load, must be below the effective modulus
//   q        - cell-bank state
//   j, k     - J/K drive presented to the cells
//   carry    - pulse while q shows the value just reached by a wrap
//   busy     - high in RUN or PAUSE
//   done     - pulse in the cycle after the final step of a run
//   err      - pulse after an illegal start or load request
// ---------------------------------------------------------------------------
module jk_counter_sequencer
  import jk_counter_sequencer_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DEF_MOD = 10
) (
  input  logic             clk,
  input  logic             rd,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             dir,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] run_len,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             carry,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int MW = WIDTH + 1;

  // Effective modulus held before any run has been configured. Only the
  // default 4-bit build has a preset; wider builds fall back to 2^WIDTH.
  localparam int UNCFG_M = (WIDTH == 4 && DEF_MOD >= 2 && DEF_MOD <= 16)
                           ? DEF_MOD : (1 << WIDTH);

  state_t          state_reg, state_next;
  logic            dir_reg, dir_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [MW-1:0]   meff_reg, meff_next;
  logic            carry_reg, carry_next;
  logic            busy_reg;
  logic            done_reg, done_next;
  logic            err_reg, err_next;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] step_q;
  logic             step_carry;
  logic [MW-1:0]    m_in;
  logic [MW-1:0]    q_ext;
  logic [MW-1:0]    meff_m1;

  // Effective modulus of the live input, used when loading or starting in IDLE.
  assign m_in    = MW'(m_eff(32'(modulus), WIDTH));
  assign q_ext   = {1'b0, q};
  assign meff_m1 = meff_reg - MW'(1);

  // One counting step against the latched modulus and direction.
  always_comb begin
    step_q     = q;
    step_carry = 1'b0;
    if (q_ext >= meff_reg) begin
      // Count left out of range by a modulus change: recover to 0 quietly.
      step_q = '0;
    end else if (dir_reg) begin
      if (q_ext == meff_m1) begin
        step_q     = '0;
        step_carry = 1'b1;
      end else begin
        step_q = q + WIDTH'(1);
      end
    end else begin
      if (q == '0) begin
        step_q     = meff_m1[WIDTH-1:0];
        step_carry = 1'b1;
      end else begin
        step_q = q - WIDTH'(1);
      end
    end
  end

  // Next-state decode; priority stop > load > pause > start/step.
  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    rem_next   = rem_reg;
    meff_next  = meff_reg;
    q_next     = q;
    carry_next = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (stop) begin
          // nothing to abort
        end else if (load) begin
          if ({1'b0, load_val} < m_in) q_next = load_val;
          else                         err_next = 1'b1;
        end else if (start) begin
          if (modulus == WIDTH'(1)) begin
            err_next = 1'b1;
          end else begin
            state_next = ST_RUN;
            dir_next   = dir;
            rem_next   = run_len;
            meff_next  = m_in;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (pause) begin
          state_next = ST_PAUSE;
        end else begin
          q_next     = step_q;
          carry_next = step_carry;
          if (rem_reg != '0) begin
            rem_next = rem_reg - WIDTH'(1);
            if (rem_reg == WIDTH'(1)) begin
              state_next = ST_DONE;
              done_next  = 1'b1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (load) begin
          if ({1'b0, load_val} < meff_reg) q_next = load_val;
          else                             err_next = 1'b1;
        end else if (!pause) begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rd) begin
      state_reg <= ST_IDLE;
      dir_reg   <= 1'b0;
      rem_reg   <= '0;
      meff_reg  <= MW'(UNCFG_M);
      carry_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      rem_reg   <= rem_next;
      meff_reg  <= meff_next;
      carry_reg <= carry_next;
      busy_reg  <= (state_next == ST_RUN) || (state_next == ST_PAUSE);
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // Toggle encoding: only bits that differ between q and q_next are driven.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_drive
      assign j[gi] = jk_toggle(q[gi], q_next[gi]);
      assign k[gi] = jk_toggle(q[gi], q_next[gi]);
    end
  endgenerate

  jk_cell_bank #(
    .WIDTH (WIDTH)
  ) u_cells (
    .clk (clk),
    .rd  (rd),
    .j   (j),
    .k   (k),
    .q   (q)
  );

  assign carry = carry_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_jk_counter_sequencer.sv
module tb_jk_counter_sequencer;

  logic       clk = 1'b0;
  logic       rd, start, stop, pause, dir, load;
  logic [3:0] modulus, run_len, load_val;
  logic [3:0] q, j, k;
  logic       carry, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jk_counter_sequencer #(.WIDTH(4), .DEF_MOD(10)) dut (
    .clk(clk), .rd(rd), .start(start), .stop(stop), .pause(pause),
    .dir(dir), .modulus(modulus), .run_len(run_len), .load(load),
    .load_val(load_val), .q(q), .j(j), .k(k), .carry(carry),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic       start, stop, pause, dir, load;
    logic [3:0] modulus, run_len, load_val;
    logic [3:0] exp_q, exp_jk;
    logic       exp_busy, exp_carry, exp_done, exp_err;
  } vec_t;

  vec_t vecs [0:31];
  int   nvec = 0;

  task automatic add(input logic st, sp, pa, dr, ld,
                     input logic [3:0] m, rl, lv, eq, ejk,
                     input logic eb, ec, ed, ee);
    vecs[nvec].start = st;  vecs[nvec].stop = sp; vecs[nvec].pause = pa;
    vecs[nvec].dir = dr;    vecs[nvec].load = ld;
    vecs[nvec].modulus = m; vecs[nvec].run_len = rl; vecs[nvec].load_val = lv;
    vecs[nvec].exp_q = eq;  vecs[nvec].exp_jk = ejk;
    vecs[nvec].exp_busy = eb; vecs[nvec].exp_carry = ec;
    vecs[nvec].exp_done = ed; vecs[nvec].exp_err = ee;
    nvec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic drive(input logic st, sp, pa, dr, ld, input logic [3:0] m, rl, lv);
    start = st; stop = sp; pause = pa; dir = dr; load = ld;
    modulus = m; run_len = rl; load_val = lv;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eq, ejk,
                         input logic eb, ec, ed, ee);
    check({tag, "_q"},     32'(q),     32'(eq));
    check({tag, "_j"},     32'(j),     32'(ejk));
    check({tag, "_k"},     32'(k),     32'(ejk));
    check({tag, "_busy"},  32'(busy),  32'(eb));
    check({tag, "_carry"}, 32'(carry), 32'(ec));
    check({tag, "_done"},  32'(done),  32'(ed));
    check({tag, "_err"},   32'(err),   32'(ee));
    $display("%s: q=%0d j=%b k=%b busy=%b carry=%b done=%b err=%b",
             tag, q, j, k, busy, carry, done, err);
  endtask

  initial begin
    // start stop pause dir load mod rl lv | q jk busy carry done err
    // Up, mod 10, free-run: 0..9 then wrap with carry, then stop.
    add(1,0,0,1,0, 10,0,0,  0,4'b0001, 1,0,0,0);
    add(0,0,0,1,0, 10,0,0,  1,4'b0011, 1,0,0,0);
    add(0,0,0,1,0, 10,0,0,  2,4'b0001, 1,0,0,0);
    add(0,0,0,1,0, 10,0,0,  3,4'b0111, 1,0,0,0);
    add(0,0,0,1,0, 10,0,0,  4,4'b0001, 1,0,0,0);
    add(0,0,0,1,0, 10,0,0,  5,4'b0011, 1,0,0,0);
    add(0,0,0,1,0, 10,0,0,  6,4'b0001, 1,0,0,0);
    add(0,0,0,1,0, 10,0,0,  7,4'b1111, 1,0,0,0);
    add(0,0,0,1,0, 10,0,0,  8,4'b0001, 1,0,0,0);
    add(0,0,0,1,0, 10,0,0,  9,4'b1001, 1,0,0,0);
    add(0,0,0,1,0, 10,0,0,  0,4'b0001, 1,1,0,0);
    add(0,0,0,1,0, 10,0,0,  1,4'b0011, 1,0,0,0);
    add(0,1,0,1,0, 10,0,0,  1,4'b0000, 0,0,0,0);
    // Preload 2, down mod 6 for 4 steps: 2,1,0,5,4 then done.
    add(0,0,0,0,1,  6,4,2,  2,4'b0000, 0,0,0,0);
    add(1,0,0,0,0,  6,4,2,  2,4'b0011, 1,0,0,0);
    add(0,0,0,0,0,  6,4,2,  1,4'b0001, 1,0,0,0);
    add(0,0,0,0,0,  6,4,2,  0,4'b0101, 1,0,0,0);
    add(0,0,0,0,0,  6,4,2,  5,4'b0001, 1,1,0,0);
    add(0,0,0,0,0,  6,4,2,  4,4'b0000, 0,0,1,0);
    add(0,0,0,0,0,  6,4,2,  4,4'b0000, 0,0,0,0);
    // Illegal requests and load/start interplay in IDLE.
    add(1,0,0,1,0,  1,0,0,  4,4'b0000, 0,0,0,1);
    add(0,0,0,1,1, 10,0,12, 4,4'b0000, 0,0,0,1);
    add(1,0,0,1,1, 10,0,3,  3,4'b0000, 0,0,0,0);
    add(0,0,0,1,0, 10,0,3,  3,4'b0000, 0,0,0,0);
    add(0,0,0,1,1, 10,0,9,  9,4'b0000, 0,0,0,0);

    // Reset then idle.
    drive(0,0,0,0,0, 0,0,0);
    rd = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rd = 1'b0;
    tick();
    chk_out("reset", 4'd0, 4'b0000, 0,0,0,0);

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].dir, vecs[i].load,
            vecs[i].modulus, vecs[i].run_len, vecs[i].load_val);
      tick();
      chk_out($sformatf("row%0d", i), vecs[i].exp_q, vecs[i].exp_jk,
              vecs[i].exp_busy, vecs[i].exp_carry, vecs[i].exp_done, vecs[i].exp_err);
    end

    // Load ignored during RUN, then pause 3 cycles, resume, stop+pause.
    drive(1,0,0,1,0, 10,0,0); tick();
    chk_out("ps_start", 4'd9, 4'b1001, 1,0,0,0);
    drive(0,0,0,1,1, 10,0,5); tick();
    chk_out("ps_load_run", 4'd0, 4'b0001, 1,1,0,0);
    drive(0,0,0,1,0, 10,0,0); tick();
    chk_out("ps_step", 4'd1, 4'b0011, 1,0,0,0);
    drive(0,0,1,1,0, 10,0,0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out($sformatf("ps_pause%0d", c), 4'd1, 4'b0000, 1,0,0,0);
    end
    drive(0,0,0,1,0, 10,0,0); tick();
    chk_out("ps_resume", 4'd1, 4'b0011, 1,0,0,0);
    tick();
    chk_out("ps_step2", 4'd2, 4'b0001, 1,0,0,0);
    drive(0,1,1,1,0, 10,0,0); tick();
    chk_out("ps_stop", 4'd2, 4'b0000, 0,0,0,0);
    drive(0,0,0,1,0, 10,0,0); tick();
    chk_out("ps_after", 4'd2, 4'b0000, 0,0,0,0);

    // Out-of-range count at start: q=9 with M=6 recovers to 0, no carry.
    drive(0,0,0,1,1, 10,0,9); tick();
    chk_out("oor_load", 4'd9, 4'b0000, 0,0,0,0);
    drive(1,0,0,1,0, 6,2,0); tick();
    chk_out("oor_start", 4'd9, 4'b1001, 1,0,0,0);
    drive(0,0,0,1,0, 6,2,0); tick();
    chk_out("oor_step", 4'd0, 4'b0001, 1,0,0,0);
    tick();
    chk_out("oor_done", 4'd1, 4'b0000, 0,0,1,0);
    tick();
    chk_out("oor_idle", 4'd1, 4'b0000, 0,0,0,0);

    // Full range (modulus 0): 14,15 wrap to 0 with carry, reset mid-run.
    drive(0,0,0,1,1, 0,0,14); tick();
    chk_out("fr_load", 4'd14, 4'b0000, 0,0,0,0);
    drive(1,0,0,1,0, 0,0,0); tick();
    chk_out("fr_start", 4'd14, 4'b0001, 1,0,0,0);
    drive(0,0,0,1,0, 0,0,0); tick();
    chk_out("fr_15", 4'd15, 4'b1111, 1,0,0,0);
    tick();
    chk_out("fr_wrap", 4'd0, 4'b0001, 1,1,0,0);
    tick();
    chk_out("fr_1", 4'd1, 4'b0011, 1,0,0,0);
    rd = 1'b1; tick();
    chk_out("fr_rst", 4'd0, 4'b0000, 0,0,0,0);
    rd = 1'b0; tick();
    chk_out("fr_idle", 4'd0, 4'b0000, 0,0,0,0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
